// File: rtl/dadda_pkg.sv
// Shared widths and the Dadda reduction schedule for the 8x8+16 multiply-accumulate slice.
// The schedule functions are evaluated at elaboration time to size and wire each tree stage.
package dadda_pkg;

   localparam int A_W = 8;
   localparam int X_W = 16;
   localparam int R_W = 17;
   localparam int NR  = 4;
   localparam int MH  = 9;
   localparam int DADDA_SEQ [NR] = '{6, 4, 3, 2};

   // Partial-product bits landing in column c (x adds one more bit to every column 0..15).
   function automatic int pp_count(input int c);
      int res;
      res = 0;
      if (c < A_W)              res = c + 1;
      else if (c < 2 * A_W - 1) res = 2 * A_W - 1 - c;
      return res;
   endfunction

   // kind 0: column height entering stage s; 1: full adders; 2: half adders;
   // 3: carries arriving from column c-1 during stage s.
   function automatic int sched(input int s, input int c, input int kind);
      logic [4*X_W-1:0] h;
      int cin, exc, fa, ha, hi, res;
      res = 0;
      for (int i = 0; i < X_W; i++) h[4*i +: 4] = 4'(pp_count(i) + 1);
      for (int st = 0; st < NR; st++) begin
         cin = 0;
         for (int i = 0; i < X_W; i++) begin
            hi  = int'(h[4*i +: 4]);
            exc = hi + cin - DADDA_SEQ[st];
            fa  = (exc > 0) ? exc / 2 : 0;
            ha  = (exc > 0) ? exc % 2 : 0;
            if (st == s && i == c) begin
               case (kind)
                  0:       res = hi;
                  1:       res = fa;
                  2:       res = ha;
                  default: res = cin;
               endcase
            end
            h[4*i +: 4] = 4'(hi - 2 * fa - ha + cin);
            cin = fa + ha;
         end
      end
      if (s == NR && kind == 0) res = int'(h[4*c +: 4]);
      return res;
   endfunction

endpackage

// File: rtl/dadda_mult_full_adder.sv
// 3:2 compressor cell used throughout the reduction tree and the final ripple adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/dadda_mult.sv
// Registered a*b + x: partial products plus x feed a Dadda tree (9 -> 6 -> 4 -> 3 -> 2 rows),
// a 16-bit ripple adder finishes the sum, and {cout, mult_out} is captured every clock.
module dadda_mult
   import dadda_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [A_W-1:0]    a,
   input  logic [A_W-1:0]    b,
   input  logic [X_W-1:0]    x,
   output logic [X_W-1:0]    mult_out,
   output logic              cout
);

   // col_bits[st][c] holds the bits of weight 2^c entering stage st, packed from index 0.
   logic [MH-1:0] col_bits [0:NR][0:X_W-1];
   logic [MH-1:0] carry    [0:NR-1][0:X_W-1];

   for (genvar c = 0; c < X_W; c++) begin : g_pp_col
      localparam int NPP = pp_count(c);
      localparam int LO  = (c > A_W - 1) ? c - (A_W - 1) : 0;
      for (genvar k = 0; k < NPP; k++) begin : g_pp
         assign col_bits[0][c][k] = a[c-LO-k] & b[LO+k];
      end
      assign col_bits[0][c][NPP] = x[c];
      for (genvar k = NPP + 1; k < MH; k++) begin : g_zero
         assign col_bits[0][c][k] = 1'b0;
      end
   end

   for (genvar st = 0; st < NR; st++) begin : g_stage
      for (genvar c = 0; c < X_W; c++) begin : g_col
         localparam int H     = sched(st, c, 0);
         localparam int FA    = sched(st, c, 1);
         localparam int HA    = sched(st, c, 2);
         localparam int CI    = sched(st, c, 3);
         localparam int NSUM  = FA + HA;
         localparam int NPASS = H - 3 * FA - 2 * HA;

         for (genvar k = 0; k < FA; k++) begin : g_fa
            full_adder u_fa (
               .a   (col_bits[st][c][3*k]),
               .b   (col_bits[st][c][3*k+1]),
               .cin (col_bits[st][c][3*k+2]),
               .sum (col_bits[st+1][c][k]),
               .cout(carry[st][c][k])
            );
         end
         for (genvar k = 0; k < HA; k++) begin : g_ha
            assign col_bits[st+1][c][FA+k] = col_bits[st][c][3*FA+2*k] ^ col_bits[st][c][3*FA+2*k+1];
            assign carry[st][c][FA+k]      = col_bits[st][c][3*FA+2*k] & col_bits[st][c][3*FA+2*k+1];
         end
         for (genvar k = 0; k < NPASS; k++) begin : g_pass
            assign col_bits[st+1][c][NSUM+k] = col_bits[st][c][3*FA+2*HA+k];
         end
         // Carries from the column below land after this column's sums and pass-through bits.
         for (genvar k = 0; k < CI; k++) begin : g_cin
            assign col_bits[st+1][c][NSUM+NPASS+k] = carry[st][c-1][k];
         end
         for (genvar k = NSUM + NPASS + CI; k < MH; k++) begin : g_zero
            assign col_bits[st+1][c][k] = 1'b0;
         end
         for (genvar k = NSUM; k < MH; k++) begin : g_czero
            assign carry[st][c][k] = 1'b0;
         end
      end
   end

   logic [X_W:0]   cpa_c;
   logic [X_W-1:0] cpa_s;

   assign cpa_c[0] = 1'b0;
   for (genvar c = 0; c < X_W; c++) begin : g_cpa
      full_adder u_cpa (
         .a   (col_bits[NR][c][0]),
         .b   (col_bits[NR][c][1]),
         .cin (cpa_c[c]),
         .sum (cpa_s[c]),
         .cout(cpa_c[c+1])
      );
   end

   logic [X_W-1:0] mult_d, mult_q;
   logic           cout_d, cout_q;

   // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
   always_comb begin
      mult_d = cpa_s;
      cout_d = cpa_c[X_W];
   end

   // NOTE: state updates use non-blocking assignment so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mult_q <= '0;
         cout_q <= 1'b0;
      end else begin
         mult_q <= mult_d;
         cout_q <= cout_d;
      end
   end

   assign mult_out = mult_q;
   assign cout     = cout_q;

endmodule

// File: tb/tb_dadda_mult.sv
// Self-checking bench for dadda_mult: directed vectors, an exhaustive a/b sweep with varied x,
// random vectors and a mid-cycle asynchronous reset, all against an arithmetic reference model.
module tb_dadda_mult;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  a, b;
   logic [15:0] x;
   logic [15:0] mult_out;
   logic        cout;

   int          checks = 0;
   int          errors = 0;
   logic [16:0] last_exp;

   always #5 clk = ~clk;

   dadda_mult dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .x       (x),
      .mult_out(mult_out),
      .cout    (cout)
   );

   function automatic logic [16:0] ref_mac(input logic [7:0] av, input logic [7:0] bv,
                                           input logic [15:0] xv);
      int unsigned r;
      r = int'(av) * int'(bv) + int'(xv);
      return r[16:0];
   endfunction

   task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge: drive, confirm the outputs still hold the previous result,
   // then confirm the new result one rising edge later.
   task automatic drive_chk(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [15:0] xv, input logic [16:0] exp);
      a = av;
      b = bv;
      x = xv;
      #1;
      check({tag, "_hold"}, {cout, mult_out}, last_exp);
      @(negedge clk);
      check(tag, {cout, mult_out}, exp);
      last_exp = exp;
   endtask

   initial begin
      logic [15:0] xv;
      rst_n = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      x = 16'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset", {cout, mult_out}, 17'h0_0000);

      rst_n    = 1'b1;
      last_exp = 17'h0_0000;
      drive_chk("first",  8'd70,  8'd20,  16'h1111, 17'h0_1689);
      drive_chk("vec2",   8'd79,  8'd69,  16'h00FF, 17'h0_164A);
      drive_chk("vec3",   8'd74,  8'd113, 16'h2222, 17'h0_42CC);
      drive_chk("carry1", 8'd215, 8'd200, 16'hFF00, 17'h1_A6F8);
      drive_chk("carry2", 8'd93,  8'd7,   16'hFFFF, 17'h1_028A);
      drive_chk("max",    8'hFF,  8'hFF,  16'hFFFF, 17'h1_FE00);
      drive_chk("zero",   8'h00,  8'hFF,  16'h0000, 17'h0_0000);

      a = 8'hFF;
      b = 8'hFF;
      x = 16'hFFFF;
      @(posedge clk);
      #2;
      check("pre_rst", {cout, mult_out}, 17'h1_FE00);
      rst_n = 1'b0;
      #1;
      check("rst_async", {cout, mult_out}, 17'h0_0000);
      @(negedge clk);
      check("rst_hold", {cout, mult_out}, 17'h0_0000);
      rst_n    = 1'b1;
      last_exp = 17'h0_0000;
      drive_chk("post_rst", 8'd70, 8'd20, 16'h1111, 17'h0_1689);

      for (int ai = 0; ai < 256; ai++) begin
         for (int bi = 0; bi < 256; bi++) begin
            case ((ai * 256 + bi) % 3)
               0:       xv = 16'h0000;
               1:       xv = 16'hFFFF;
               default: xv = 16'($urandom);
            endcase
            drive_chk("sweep", 8'(ai), 8'(bi), xv, ref_mac(8'(ai), 8'(bi), xv));
         end
      end

      for (int i = 0; i < 1000; i++) begin
         logic [7:0] av, bv;
         av = 8'($urandom);
         bv = 8'($urandom);
         xv = 16'($urandom);
         drive_chk("random", av, bv, xv, ref_mac(av, bv, xv));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
